// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the state encoding, opcode values and program-counter width.
package fetch_pkg;

    localparam int ADDR_W = 12;

    localparam logic [3:0] OPC_JMP  = 4'hE;
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        VALID,
        JUMP2,
        LOAD,
        HALTED
    } state_t;

    // A JMP carries the high target nibble in its operand field
    // and the low target byte in the following ROM location.
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [3:0] hi,
        input logic [7:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the ROM through an external program counter,
// presents instructions to execute, and resolves two-byte jumps itself.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [7:0]        rom_data,
    input  logic              instr_ready,
    output logic              pc_enable,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_bload,
    output logic [7:0]        instr,
    output logic              instr_valid,
    output logic              halted
);

    state_t            state;
    logic [ADDR_W-1:0] fetch_addr;

    // State machine; every strobe is a flop set on entry to the state
    // that owns it, so pc_load and pc_enable are glitch-free and disjoint.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc_enable   <= 1'b0;
            pc_load     <= 1'b0;
            pc_bload    <= '0;
            instr       <= 8'h00;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_addr  <= '0;
        end else begin
            pc_enable   <= 1'b0;
            pc_load     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        pc_enable <= 1'b1;
                    end
                end
                FETCH: begin
                    instr      <= rom_data;
                    fetch_addr <= pc_addr;
                    if (rom_data[7:4] == OPC_JMP) begin
                        state     <= JUMP2;
                        pc_enable <= 1'b1;
                    end else if (rom_data[7:4] == OPC_HALT) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        state       <= VALID;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        state     <= FETCH;
                        pc_enable <= 1'b1;
                    end else begin
                        instr_valid <= 1'b1;
                    end
                end
                JUMP2: begin
                    pc_bload <= jump_target(instr[3:0], rom_data);
                    state    <= LOAD;
                    pc_load  <= 1'b1;
                end
                LOAD: begin
                    state     <= FETCH;
                    pc_enable <= 1'b1;
                end
                HALTED: begin
                    if (start) begin
                        state     <= FETCH;
                        pc_enable <= 1'b1;
                    end else begin
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The counter must have stepped past the JMP opcode before its
    // second byte is taken as the low half of the target.
    always_ff @(posedge clk) begin
        if (reset && state == JUMP2) begin
            assert (pc_addr == ADDR_W'(fetch_addr + 1'b1));
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a ROM and program counter
// model; expectations come from an instruction-level program walk.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] pc_addr;
    logic [7:0]  rom_data;
    logic        instr_ready;
    logic        pc_enable;
    logic        pc_load;
    logic [11:0] pc_bload;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        halted;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_instr;
    logic [11:0] m_bload;
    logic [11:0] p;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_addr     (pc_addr),
        .rom_data    (rom_data),
        .instr_ready (instr_ready),
        .pc_enable   (pc_enable),
        .pc_load     (pc_load),
        .pc_bload    (pc_bload),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign pc_addr  = pc;
    assign rom_data = rom[pc];

    // Program counter seen by the sequencer
    always_ff @(posedge clk) begin
        if (!reset)        pc <= 12'h000;
        else if (pc_load)  pc <= pc_bload;
        else if (pc_enable) pc <= pc + 12'd1;
    end

    wire [23:0] obs = {pc_enable, pc_load, pc_bload,
                       instr, instr_valid, halted};

    function automatic logic [23:0] ex(
        input logic en, input logic ld, input logic [11:0] bl,
        input logic [7:0] ins, input logic v, input logic h);
        return {en, ld, bl, ins, v, h};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [23:0] o,
                       input logic [23:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [23:0] e,
                        input logic st, input logic rdy);
        @(negedge clk);
        chk(tag, obs, e);
        start       = st;
        instr_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        m_instr = 8'h00;
        m_bload = 12'h000;
        p       = 12'h000;
        chk("reset", obs, 24'h0);
        chk("reset_pc", {12'h0, pc}, 24'h0);
    endtask

    task automatic idle_start(input int n);
        for (int i = 0; i < n; i++)
            step("idle", ex(0, 0, m_bload, m_instr, 0, 0), 1'b0, rnd());
        step("idle_go", ex(0, 0, m_bload, m_instr, 0, 0), 1'b1, rnd());
    endtask

    // Execute the instruction at p: w = ready stall cycles,
    // hw = cycles spent halted before start is raised.
    task automatic exec_one(input int w, input int hw);
        logic [7:0]  b;
        logic [11:0] nx;
        step("fetch", ex(1, 0, m_bload, m_instr, 0, 0), rnd(), rnd());
        chk("fetch_pc", {12'h0, pc}, {12'h0, p});
        b       = rom[p];
        nx      = p + 12'd1;
        m_instr = b;
        if (b[7:4] == OPC_JMP) begin
            step("jump2", ex(1, 0, m_bload, m_instr, 0, 0), rnd(), rnd());
            chk("jump2_pc", {12'h0, pc}, {12'h0, nx});
            m_bload = {b[3:0], rom[nx]};
            step("load", ex(0, 1, m_bload, m_instr, 0, 0), rnd(), rnd());
            p = m_bload;
        end else if (b[7:4] == OPC_HALT) begin
            for (int i = 0; i <= hw; i++)
                step("halted", ex(0, 0, m_bload, m_instr, 0, 1),
                     (i == hw), rnd());
            p = nx;
        end else begin
            for (int i = 0; i <= w; i++)
                step("valid", ex(0, 0, m_bload, m_instr, 1, 0),
                     rnd(), (i == w));
            p = nx;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        instr_ready = 1'b0;
        clear_rom();

        // Reset values
        do_reset();
        step("idle_hold", 24'h0, 1'b0, 1'b1);

        // Two plain instructions back to back
        rom[0] = 8'h12;
        rom[1] = 8'h34;
        idle_start(1);
        exec_one(0, 0);
        exec_one(0, 0);

        // Jump to 0x1A0
        do_reset();
        clear_rom();
        rom[0]     = 8'hE1;
        rom[1]     = 8'hA0;
        rom[12'h1A0] = 8'h56;
        idle_start(0);
        exec_one(0, 0);
        exec_one(0, 0);

        // Execute stage stalls for five cycles
        do_reset();
        clear_rom();
        rom[0] = 8'h77;
        rom[1] = 8'h88;
        idle_start(0);
        exec_one(5, 0);
        exec_one(1, 0);

        // Halt on third fetch and resume after it
        do_reset();
        clear_rom();
        rom[0] = 8'h11;
        rom[1] = 8'h22;
        rom[2] = 8'hF0;
        rom[3] = 8'h33;
        idle_start(0);
        exec_one(0, 0);
        exec_one(0, 0);
        exec_one(0, 3);
        exec_one(0, 0);

        // Jump whose first byte sits at 0xFFF
        do_reset();
        clear_rom();
        rom[0]       = 8'hEF;
        rom[1]       = 8'hFF;
        rom[12'hFFF] = 8'hE1;
        rom[12'h1EF] = 8'h44;
        idle_start(0);
        exec_one(0, 0);
        exec_one(0, 0);
        exec_one(0, 0);

        // Jump to self keeps looping
        do_reset();
        clear_rom();
        rom[0] = 8'hE0;
        rom[1] = 8'h00;
        idle_start(0);
        repeat (4) exec_one(0, 0);

        // Reset while the load strobe is high
        do_reset();
        clear_rom();
        rom[0] = 8'hE1;
        rom[1] = 8'hA0;
        idle_start(0);
        step("rl_fetch", ex(1, 0, 12'h000, 8'h00, 0, 0), 1'b0, 1'b0);
        step("rl_jump2", ex(1, 0, 12'h000, 8'hE1, 0, 0), 1'b0, 1'b0);
        step("rl_load", ex(0, 1, 12'h1A0, 8'hE1, 0, 0), 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_load", obs, 24'h0);
        chk("rst_in_load_pc", {12'h0, pc}, 24'h0);
        reset = 1'b1;

        // Random program with random stalls and halts
        do_reset();
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        idle_start(1);
        for (int i = 0; i < 400; i++)
            exec_one($urandom_range(0, 2), $urandom_range(0, 2));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
